pac_mover: RTL and testbench
============================

PAC_MOVER -- requirements
Module: pac_mover

Interface
REQ-001 SHALL have parameter GRID_W, default 96, tile columns.
REQ-002 SHALL have parameter GRID_H, default 72, tile rows.
REQ-003 SHALL have parameter START_X, default 7, reset column.
REQ-004 SHALL have parameter START_Y, default 64, reset row.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port tick  in  1  one-cycle move strobe (one per movement step).
REQ-008 SHALL have port dir_valid  in  1  direction request strobe.
REQ-009 SHALL have port dir_req  in  2  requested direction: 0 up, 1 down, 2 left, 3 right.
REQ-010 SHALL have port freeze  in  1  high blocks movement (driven from gamewin).
REQ-011 SHALL have port wall_req  out  1  maze-lookup request.
REQ-012 SHALL have port wall_x  out  10  queried column.
REQ-013 SHALL have port wall_y  out  9  queried row.
REQ-014 SHALL have port wall_ack  in  1  lookup response valid.
REQ-015 SHALL have port wall_hit  in  1  queried tile is wall; valid with wall_ack.
REQ-016 SHALL have port xPacLoc  out  10  current column, feeds food consumer.
REQ-017 SHALL have port yPacLoc  out  9  current row.
REQ-018 SHALL have port cur_dir  out  2  direction of travel.
REQ-019 SHALL have port moving  out  1  high if last step attempt succeeded.
REQ-020 SHALL have port tick_miss  out  1  sticky: tick arrived while not IDLE.

Function
REQ-021 SHALL latch dir_req into pending register on dir_valid in any state; later request overwrites earlier.
REQ-022 SHALL implement FSM IDLE, TRY_PEND, TRY_CUR.
REQ-023 IDLE: tick & !freeze & pending valid & pending != cur_dir -> TRY_PEND; tick & !freeze otherwise -> TRY_CUR; else stay.
REQ-024 SHALL hold wall_req high and wall_x/wall_y stable in TRY_PEND/TRY_CUR until the edge sampling wall_ack=1; wall_req low in IDLE.
REQ-025 TRY_PEND ack & !hit: cur_dir<=pending, pending cleared, position steps, moving<=1, -> IDLE.
REQ-026 TRY_PEND ack & hit: -> TRY_CUR (pending kept).
REQ-027 TRY_CUR ack & !hit: position steps by cur_dir, moving<=1, -> IDLE; ack & hit: moving<=0, position held, -> IDLE.
REQ-028 Position SHALL update on the edge sampling ack; visible on outputs the following cycle; latency tick->move 2 cycles minimum with zero-wait ack.
REQ-029 freeze high at the ack edge SHALL suppress the step and direction change; FSM still returns IDLE.
REQ-030 tick while not IDLE SHALL be ignored and set tick_miss; tick_miss cleared only by reset.
REQ-031 Coordinates SHALL stay within 0..GRID_W-1 / 0..GRID_H-1 at all times.

Reset
REQ-032 reset low SHALL asynchronously force IDLE, xPacLoc=START_X, yPacLoc=START_Y, cur_dir=left, pending invalid, moving=0, wall_req=0, wall_x/wall_y=0, tick_miss=0; an in-flight lookup is abandoned and a late ack ignored.

Configuration
REQ-033 With PAC_WRAP_EN defined, a step past column 0/GRID_W-1 SHALL wrap to the opposite column (tunnel) and the wrapped tile is queried; rows never wrap.
REQ-034 Without PAC_WRAP_EN, any step leaving the grid SHALL be treated as wall_hit without issuing wall_req, resolving in one cycle.

Structure
REQ-035 Shared package pac_pkg SHALL hold dir_t enum, GRID_W/GRID_H defaults and the FSM state typedef.
REQ-036 Target-cell computation (step, wrap/edge detect) SHALL live in combinational sub-module pac_next_cell.

Verification
REQ-037 Reset at (7,64); tick, ack next cycle hit=0, dir left with wrap disabled -> x edge? no: x=6, y=64, moving=1 two cycles after tick.
REQ-038 dir_valid up, tick, TRY_PEND ack hit=1, TRY_CUR ack hit=0 -> cur_dir stays left, x decrements, pending retained.
REQ-039 Wrap enabled at x=0 dir left, ack hit=0 -> wall_x=95, xPacLoc=95; disabled -> no wall_req, x=0, moving=0.
REQ-040 Delay ack 5 cycles, tick mid-wait -> tick ignored, tick_miss=1, wall_x/wall_y stable throughout.
REQ-041 freeze=1 at ack with hit=0 -> position, cur_dir unchanged; reset low while wall_req high -> IDLE, (7,64) immediately.

Source files
------------

// File: rtl/pac_pkg.sv
// pac_pkg -- shared types and defaults for the pac-man mover.
//   dir_t      : direction encoding (0 up, 1 down, 2 left, 3 right)
//   state_t    : mover FSM state (IDLE, TRY_PEND, TRY_CUR)
//   DEF_GRID_W : default maze width in tiles
//   DEF_GRID_H : default maze height in tiles
package pac_pkg;

   localparam int DEF_GRID_W = 96;
   localparam int DEF_GRID_H = 72;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TRY_PEND = 2'd1,
      ST_TRY_CUR  = 2'd2
   } state_t;

endpackage

// File: rtl/pac_next_cell.sv
// pac_next_cell -- combinational target-tile computation for one step.
// Configuration macro: PAC_WRAP_EN (horizontal tunnel wrap; rows never wrap).
// Ports:
//   x, y      : current tile
//   dir       : direction of the step being evaluated
//   nx, ny    : target tile (equals current tile when off_grid is set)
//   off_grid  : step would leave the maze; caller treats it as a wall
module pac_next_cell
   import pac_pkg::*;
#(
   parameter int GRID_W = DEF_GRID_W,
   parameter int GRID_H = DEF_GRID_H
) (
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic [1:0] dir,
   output logic [9:0] nx,
   output logic [8:0] ny,
   output logic       off_grid
);

   localparam logic [9:0] X_MAX = 10'(GRID_W - 1);
   localparam logic [8:0] Y_MAX = 9'(GRID_H - 1);

   always_comb begin
      nx       = x;
      ny       = y;
      off_grid = 1'b0;
      case (dir_t'(dir))
         DIR_UP: begin
            if (y == 9'd0) off_grid = 1'b1;
            else           ny = y - 9'd1;
         end
         DIR_DOWN: begin
            if (y == Y_MAX) off_grid = 1'b1;
            else            ny = y + 9'd1;
         end
         DIR_LEFT: begin
`ifdef PAC_WRAP_EN
            if (x == 10'd0) nx = X_MAX;
            else            nx = x - 10'd1;
`else
            if (x == 10'd0) off_grid = 1'b1;
            else            nx = x - 10'd1;
`endif
         end
         DIR_RIGHT: begin
`ifdef PAC_WRAP_EN
            if (x == X_MAX) nx = 10'd0;
            else            nx = x + 10'd1;
`else
            if (x == X_MAX) off_grid = 1'b1;
            else            nx = x + 10'd1;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pac_mover.sv
// pac_mover -- tile-stepping movement controller with maze-lookup handshake.
// Configuration macro: PAC_WRAP_EN (enables left/right tunnel wrap).
// Ports:
//   clk, reset (async, active-low)
//   tick              : one-cycle move strobe
//   dir_valid/dir_req : queue a requested direction (latest wins)
//   freeze            : blocks movement
//   wall_req/wall_x/wall_y -> maze lookup; wall_ack/wall_hit <- response
//   xPacLoc/yPacLoc   : current tile
//   cur_dir           : direction of travel
//   moving            : last step attempt succeeded
//   tick_miss         : sticky, a tick arrived while a lookup was in flight
module pac_mover
   import pac_pkg::*;
#(
   parameter int GRID_W  = DEF_GRID_W,
   parameter int GRID_H  = DEF_GRID_H,
   parameter int START_X = 7,
   parameter int START_Y = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       dir_valid,
   input  logic [1:0] dir_req,
   input  logic       freeze,
   output logic       wall_req,
   output logic [9:0] wall_x,
   output logic [8:0] wall_y,
   input  logic       wall_ack,
   input  logic       wall_hit,
   output logic [9:0] xPacLoc,
   output logic [8:0] yPacLoc,
   output logic [1:0] cur_dir,
   output logic       moving,
   output logic       tick_miss
);

   state_t     state_reg,      state_next;
   logic [9:0] x_reg,          x_next;
   logic [8:0] y_reg,          y_next;
   dir_t       cur_dir_reg,    cur_dir_next;
   logic       pend_valid_reg, pend_valid_next;
   dir_t       pend_dir_reg,   pend_dir_next;
   logic       moving_reg,     moving_next;
   logic       wall_req_reg,   wall_req_next;
   logic [9:0] wall_x_reg,     wall_x_next;
   logic [8:0] wall_y_reg,     wall_y_next;
   logic       off_reg,        off_next;      // current query target lies off the grid
   logic       tick_miss_reg,  tick_miss_next;

   logic       pend_differs;
   dir_t       query_dir;
   logic [9:0] nc_x;
   logic [8:0] nc_y;
   logic       nc_off;
   logic       ack_eff;
   logic       hit_eff;
   logic       load_query;

   // The pending direction is only tried when it would actually turn us.
   always_comb begin
      pend_differs = pend_valid_reg && (pend_dir_reg != cur_dir_reg);
      query_dir    = (state_reg == ST_IDLE && pend_differs) ? pend_dir_reg : cur_dir_reg;
   end

   pac_next_cell #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_next_cell (
      .x        (x_reg),
      .y        (y_reg),
      .dir      (query_dir),
      .nx       (nc_x),
      .ny       (nc_y),
      .off_grid (nc_off)
   );

   // An off-grid target never reaches the maze: it resolves as a wall on the
   // first cycle in the TRY state, and any stray ack is masked by it.
   assign ack_eff = off_reg | wall_ack;
   assign hit_eff = off_reg | wall_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         x_reg          <= 10'(START_X);
         y_reg          <= 9'(START_Y);
         cur_dir_reg    <= DIR_LEFT;
         pend_valid_reg <= 1'b0;
         pend_dir_reg   <= DIR_LEFT;
         moving_reg     <= 1'b0;
         wall_req_reg   <= 1'b0;
         wall_x_reg     <= 10'd0;
         wall_y_reg     <= 9'd0;
         off_reg        <= 1'b0;
         tick_miss_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         x_reg          <= x_next;
         y_reg          <= y_next;
         cur_dir_reg    <= cur_dir_next;
         pend_valid_reg <= pend_valid_next;
         pend_dir_reg   <= pend_dir_next;
         moving_reg     <= moving_next;
         wall_req_reg   <= wall_req_next;
         wall_x_reg     <= wall_x_next;
         wall_y_reg     <= wall_y_next;
         off_reg        <= off_next;
         tick_miss_reg  <= tick_miss_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      x_next          = x_reg;
      y_next          = y_reg;
      cur_dir_next    = cur_dir_reg;
      pend_valid_next = pend_valid_reg;
      pend_dir_next   = pend_dir_reg;
      moving_next     = moving_reg;
      wall_req_next   = wall_req_reg;
      wall_x_next     = wall_x_reg;
      wall_y_next     = wall_y_reg;
      off_next        = off_reg;
      tick_miss_next  = tick_miss_reg;
      load_query      = 1'b0;

      if (tick && state_reg != ST_IDLE) tick_miss_next = 1'b1;

      case (state_reg)
         ST_IDLE: begin
            wall_req_next = 1'b0;
            if (tick && !freeze) begin
               load_query = 1'b1;
               state_next = pend_differs ? ST_TRY_PEND : ST_TRY_CUR;
            end
         end
         ST_TRY_PEND: begin
            if (ack_eff) begin
               if (freeze) begin
                  moving_next   = 1'b0;
                  wall_req_next = 1'b0;
                  state_next    = ST_IDLE;
               end else if (!hit_eff) begin
                  // wall_x/wall_y already hold the (possibly wrapped) target
                  x_next          = wall_x_reg;
                  y_next          = wall_y_reg;
                  cur_dir_next    = pend_dir_reg;
                  pend_valid_next = 1'b0;
                  moving_next     = 1'b1;
                  wall_req_next   = 1'b0;
                  state_next      = ST_IDLE;
               end else begin
                  // turn blocked: keep the request and fall back to straight ahead
                  load_query = 1'b1;
                  state_next = ST_TRY_CUR;
               end
            end
         end
         ST_TRY_CUR: begin
            if (ack_eff) begin
               if (freeze) begin
                  moving_next = 1'b0;
               end else if (!hit_eff) begin
                  x_next      = wall_x_reg;
                  y_next      = wall_y_reg;
                  moving_next = 1'b1;
               end else begin
                  moving_next = 1'b0;
               end
               wall_req_next = 1'b0;
               state_next    = ST_IDLE;
            end
         end
         default: begin
            wall_req_next = 1'b0;
            state_next    = ST_IDLE;
         end
      endcase

      if (load_query) begin
         wall_x_next   = nc_x;
         wall_y_next   = nc_y;
         off_next      = nc_off;
         wall_req_next = !nc_off;
      end

      // A new request wins over the clear from a successful turn in the same cycle.
      if (dir_valid) begin
         pend_valid_next = 1'b1;
         pend_dir_next   = dir_t'(dir_req);
      end
   end

   assign wall_req  = wall_req_reg;
   assign wall_x    = wall_x_reg;
   assign wall_y    = wall_y_reg;
   assign xPacLoc   = x_reg;
   assign yPacLoc   = y_reg;
   assign cur_dir   = cur_dir_reg;
   assign moving    = moving_reg;
   assign tick_miss = tick_miss_reg;

endmodule

// File: tb/tb_pac_mover.sv
// tb_pac_mover -- directed scenarios followed by random walks through a
// random maze, checked against a tile-level reference model.
// Honours PAC_WRAP_EN when the design is built with it.
module tb_pac_mover;

   localparam int W = 96;
   localparam int H = 72;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       dir_valid;
   logic [1:0] dir_req;
   logic       freeze;
   logic       wall_req;
   logic [9:0] wall_x;
   logic [8:0] wall_y;
   logic       wall_ack;
   logic       wall_hit;
   logic [9:0] xPacLoc;
   logic [8:0] yPacLoc;
   logic [1:0] cur_dir;
   logic       moving;
   logic       tick_miss;

   int n_tests = 0;
   int n_fail  = 0;

   bit maze [0:W-1][0:H-1];

   // reference model state
   int mx, my, mcd, mpd, mmv;
   bit mpv;
   int eq_x[$];
   int eq_y[$];

   pac_mover dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .dir_valid (dir_valid),
      .dir_req   (dir_req),
      .freeze    (freeze),
      .wall_req  (wall_req),
      .wall_x    (wall_x),
      .wall_y    (wall_y),
      .wall_ack  (wall_ack),
      .wall_hit  (wall_hit),
      .xPacLoc   (xPacLoc),
      .yPacLoc   (yPacLoc),
      .cur_dir   (cur_dir),
      .moving    (moving),
      .tick_miss (tick_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Tile arithmetic: where does one step in direction d land, and does it leave the maze?
   task automatic model_step(input int x, input int y, input int d,
                             output int nx, output int ny, output bit off);
      nx  = x;
      ny  = y;
      off = 1'b0;
      case (d)
         0: ny = y - 1;
         1: ny = y + 1;
         2: nx = x - 1;
         default: nx = x + 1;
      endcase
      if (ny < 0 || ny >= H) off = 1'b1;
      if (nx < 0 || nx >= W) begin
`ifdef PAC_WRAP_EN
         nx = (nx + W) % W;
`else
         off = 1'b1;
`endif
      end
      if (off) begin
         nx = x;
         ny = y;
      end
   endtask

   task automatic do_tick();
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
   endtask

   task automatic dir_pulse(input int d);
      @(negedge clk); dir_valid = 1'b1; dir_req = 2'(d);
      @(negedge clk); dir_valid = 1'b0;
   endtask

   // Wait (bounded) for a lookup, check its coordinates, answer it for one cycle.
   task automatic serve(input logic hit, input int ex, input int ey, input string tag);
      int n = 0;
      while (!wall_req && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_req"}, 32'(wall_req), 32'd1);
      chk({tag, "_wx"},  32'(wall_x), 32'(ex));
      chk({tag, "_wy"},  32'(wall_y), 32'(ey));
      wall_ack = 1'b1;
      wall_hit = hit;
      @(negedge clk);
      wall_ack = 1'b0;
      wall_hit = 1'b0;
   endtask

   task automatic rand_txn(input int idx);
      int  d, nx, ny, dly, n_q, n_exp;
      bit  off, moved;
      eq_x.delete();
      eq_y.delete();
      if ($urandom_range(0, 9) < 4) begin
         d = $urandom_range(0, 3);
         dir_pulse(d);
         mpv = 1'b1;
         mpd = d;
         if ($urandom_range(0, 4) == 0) begin
            d = $urandom_range(0, 3);
            dir_pulse(d);
            mpd = d;
         end
      end
      // expected outcome: try the queued turn first, then straight ahead
      moved = 1'b0;
      if (mpv && mpd != mcd) begin
         model_step(mx, my, mpd, nx, ny, off);
         if (!off) begin eq_x.push_back(nx); eq_y.push_back(ny); end
         if (!off && !maze[nx][ny]) begin
            mx = nx; my = ny; mcd = mpd; mpv = 1'b0; mmv = 1; moved = 1'b1;
         end
      end
      if (!moved) begin
         model_step(mx, my, mcd, nx, ny, off);
         if (!off) begin eq_x.push_back(nx); eq_y.push_back(ny); end
         if (!off && !maze[nx][ny]) begin
            mx = nx; my = ny; mmv = 1;
         end else begin
            mmv = 0;
         end
      end
      n_exp = eq_x.size();
      n_q   = 0;
      dly   = $urandom_range(0, 2);
      @(negedge clk); tick = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         tick     = 1'b0;
         wall_ack = 1'b0;
         wall_hit = 1'b0;
         if (wall_req) begin
            if (dly == 0) begin
               if (eq_x.size() > 0) begin
                  chk("rnd_query_x", 32'(wall_x), 32'(eq_x.pop_front()));
                  chk("rnd_query_y", 32'(wall_y), 32'(eq_y.pop_front()));
               end
               wall_ack = 1'b1;
               wall_hit = maze[wall_x][wall_y];
               n_q++;
               dly = $urandom_range(0, 2);
            end else begin
               dly--;
            end
         end
      end
      wall_ack = 1'b0;
      chk("rnd_query_count", 32'(n_q), 32'(n_exp));
      chk("rnd_x",      32'(xPacLoc), 32'(mx));
      chk("rnd_y",      32'(yPacLoc), 32'(my));
      chk("rnd_dir",    32'(cur_dir), 32'(mcd));
      chk("rnd_moving", 32'(moving),  32'(mmv));
      $display("[TB] txn %0d pos (%0d,%0d) dir %0d moving %0d lookups %0d",
               idx, xPacLoc, yPacLoc, cur_dir, moving, n_q);
   endtask

   initial begin
      int ex_x;
      int rx;
`ifdef PAC_WRAP_EN
      ex_x = 95;
      rx   = 0;
`else
      ex_x = 0;
      rx   = 1;
`endif
      reset     = 1'b0;
      tick      = 1'b0;
      dir_valid = 1'b0;
      dir_req   = 2'd0;
      freeze    = 1'b0;
      wall_ack  = 1'b0;
      wall_hit  = 1'b0;
      for (int i = 0; i < W; i++)
         for (int j = 0; j < H; j++)
            maze[i][j] = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_x_held", 32'(xPacLoc), 32'd7);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_x",         32'(xPacLoc),   32'd7);
      chk("rst_y",         32'(yPacLoc),   32'd64);
      chk("rst_dir",       32'(cur_dir),   32'd2);
      chk("rst_moving",    32'(moving),    32'd0);
      chk("rst_wall_req",  32'(wall_req),  32'd0);
      chk("rst_wall_x",    32'(wall_x),    32'd0);
      chk("rst_wall_y",    32'(wall_y),    32'd0);
      chk("rst_tick_miss", 32'(tick_miss), 32'd0);

      // first step left, zero-wait ack: visible two cycles after tick
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      chk("s1_req", 32'(wall_req), 32'd1);
      chk("s1_wx",  32'(wall_x),   32'd6);
      chk("s1_wy",  32'(wall_y),   32'd64);
      chk("s1_x_not_yet", 32'(xPacLoc), 32'd7);
      wall_ack = 1'b1; wall_hit = 1'b0;
      @(negedge clk); wall_ack = 1'b0;
      chk("s1_x",      32'(xPacLoc),  32'd6);
      chk("s1_y",      32'(yPacLoc),  32'd64);
      chk("s1_moving", 32'(moving),   32'd1);
      chk("s1_req_lo", 32'(wall_req), 32'd0);

      // turn up blocked, fall back to left; turn stays queued
      dir_pulse(0);
      do_tick();
      serve(1'b1, 6, 63, "pend_up");
      serve(1'b0, 5, 64, "cur_left");
      chk("fb_x",      32'(xPacLoc), 32'd5);
      chk("fb_dir",    32'(cur_dir), 32'd2);
      chk("fb_moving", 32'(moving),  32'd1);
      do_tick();
      serve(1'b0, 5, 63, "pend_kept");
      chk("pk_y",   32'(yPacLoc), 32'd63);
      chk("pk_dir", 32'(cur_dir), 32'd0);

      // walk left to column 0, then step off the edge
      dir_pulse(2);
      do_tick();
      serve(1'b0, 4, 63, "walk");
      for (int k = 3; k >= 0; k--) begin
         do_tick();
         serve(1'b0, k, 63, "walk");
      end
      chk("edge_x0", 32'(xPacLoc), 32'd0);
      do_tick();
`ifdef PAC_WRAP_EN
      serve(1'b0, 95, 63, "wrap");
      chk("wrap_x",      32'(xPacLoc), 32'd95);
      chk("wrap_moving", 32'(moving),  32'd1);
`else
      chk("edge_no_req_a", 32'(wall_req), 32'd0);
      @(negedge clk);
      chk("edge_no_req_b", 32'(wall_req), 32'd0);
      chk("edge_x",        32'(xPacLoc),  32'd0);
      chk("edge_moving",   32'(moving),   32'd0);
`endif

      // slow ack with a tick arriving mid-wait
      dir_pulse(0);
      do_tick();
      chk("slow_miss_before", 32'(tick_miss), 32'd0);
      chk("slow_req0", 32'(wall_req), 32'd1);
      chk("slow_wx0",  32'(wall_x),   32'(ex_x));
      chk("slow_wy0",  32'(wall_y),   32'd62);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         tick = (c == 2);
         chk("slow_req", 32'(wall_req), 32'd1);
         chk("slow_wx",  32'(wall_x),   32'(ex_x));
         chk("slow_wy",  32'(wall_y),   32'd62);
      end
      wall_ack = 1'b1; wall_hit = 1'b0;
      @(negedge clk); wall_ack = 1'b0;
      chk("slow_x",    32'(xPacLoc),   32'(ex_x));
      chk("slow_y",    32'(yPacLoc),   32'd62);
      chk("slow_dir",  32'(cur_dir),   32'd0);
      chk("slow_miss", 32'(tick_miss), 32'd1);
      repeat (3) @(negedge clk);
      chk("slow_no_extra_y", 32'(yPacLoc),  32'd62);
      chk("slow_idle_req",   32'(wall_req), 32'd0);

      // freeze at the ack edge of a turn attempt
      dir_pulse(3);
      do_tick();
      chk("frz_req", 32'(wall_req), 32'd1);
      chk("frz_wx",  32'(wall_x),   32'(rx));
      freeze = 1'b1; wall_ack = 1'b1; wall_hit = 1'b0;
      @(negedge clk);
      freeze = 1'b0; wall_ack = 1'b0;
      chk("frz_x",      32'(xPacLoc),  32'(ex_x));
      chk("frz_y",      32'(yPacLoc),  32'd62);
      chk("frz_dir",    32'(cur_dir),  32'd0);
      chk("frz_req_lo", 32'(wall_req), 32'd0);
      do_tick();
      serve(1'b0, rx, 62, "after_frz");
      chk("afz_x",   32'(xPacLoc), 32'(rx));
      chk("afz_dir", 32'(cur_dir), 32'd3);

      // reset while a lookup is in flight, then a late ack
      do_tick();
      chk("inflight_req", 32'(wall_req), 32'd1);
      reset = 1'b0;
      #1;
      chk("arst_x",   32'(xPacLoc),  32'd7);
      chk("arst_y",   32'(yPacLoc),  32'd64);
      chk("arst_dir", 32'(cur_dir),  32'd2);
      chk("arst_req", 32'(wall_req), 32'd0);
      chk("arst_miss", 32'(tick_miss), 32'd0);
      wall_ack = 1'b1; wall_hit = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); wall_ack = 1'b0;
      chk("late_ack_x",      32'(xPacLoc),  32'd7);
      chk("late_ack_req",    32'(wall_req), 32'd0);
      chk("late_ack_moving", 32'(moving),   32'd0);

      // random walks through a random maze
      for (int i = 0; i < W; i++)
         for (int j = 0; j < H; j++)
            maze[i][j] = ($urandom_range(0, 3) == 0);
      maze[7][64] = 1'b0;
      mx = 7; my = 64; mcd = 2; mpv = 1'b0; mpd = 2; mmv = 0;
      for (int t = 0; t < 150; t++) rand_txn(t);
      chk("rnd_tick_miss", 32'(tick_miss), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
